dynamic_input_route_buffer: RTL and testbench

//  Input port of the dynamic network router: buffers flits arriving on one link,

---
 rtl/dynamic_input_route_buffer.sv | 151 +++++++++++++++
 tb/tb_dynamic_input_route_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_input_route_buffer.sv
// Router input port: credit-flow-controlled flit FIFO with header decode and
// per-direction route requests latched for the body of each packet.
module dynamic_input_route_buffer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CHIP_ID_WIDTH = 14,
    parameter int unsigned XY_WIDTH      = 8,
    parameter int unsigned PAYLOAD_LEN   = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned PTR_W         = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHIP_ID_WIDTH-1:0] my_chip_id,
    input  logic [XY_WIDTH-1:0]      my_loc_x,
    input  logic [XY_WIDTH-1:0]      my_loc_y,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     yummy_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    output logic                     tail_out,
    output logic                     route_req_n_out,
    output logic                     route_req_e_out,
    output logic                     route_req_s_out,
    output logic                     route_req_w_out,
    output logic                     route_req_p_out,
    input  logic                     thanks_n_in,
    input  logic                     thanks_e_in,
    input  logic                     thanks_s_in,
    input  logic                     thanks_w_in,
    input  logic                     thanks_p_in,
    output logic                     overflow_err
);

    typedef enum logic {HDR, BODY} state_t;

    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    state_t                   state, state_next;
    logic [PAYLOAD_LEN-1:0]   rem, rem_next;
    logic [4:0]               route_q, route_next;   // {n,e,s,w,p}
    logic [4:0]               route_dec, route_cur, thanks_vec;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [PTR_W:0]           count;
    logic                     full, push, pop;

    logic [DATA_WIDTH-1:0]    head;
    logic [CHIP_ID_WIDTH-1:0] hdr_chip;
    logic [XY_WIDTH-1:0]      hdr_x, hdr_y;
    logic [PAYLOAD_LEN-1:0]   hdr_len;
    logic                     tail_int;

    assign head     = mem[rd_ptr];
    assign hdr_chip = head[DATA_WIDTH-1 -: CHIP_ID_WIDTH];
    assign hdr_x    = head[DATA_WIDTH-CHIP_ID_WIDTH-1 -: XY_WIDTH];
    assign hdr_y    = head[DATA_WIDTH-CHIP_ID_WIDTH-XY_WIDTH-1 -: XY_WIDTH];
    assign hdr_len  = head[DATA_WIDTH-CHIP_ID_WIDTH-2*XY_WIDTH-4 -: PAYLOAD_LEN];

    assign full      = (count == FULL_COUNT);
    assign valid_out = (count != '0);

    // Off-chip traffic heads west to column 0, then north to row 0, then exits via proc.
    always_comb begin
        route_dec = '0;
        if (hdr_chip != my_chip_id) begin
            if (my_loc_x != '0)      route_dec = 5'b00010;
            else if (my_loc_y != '0) route_dec = 5'b10000;
            else                     route_dec = 5'b00001;
        end else begin
            if (hdr_x > my_loc_x)      route_dec = 5'b01000;
            else if (hdr_x < my_loc_x) route_dec = 5'b00010;
            else if (hdr_y > my_loc_y) route_dec = 5'b00100;
            else if (hdr_y < my_loc_y) route_dec = 5'b10000;
            else                       route_dec = 5'b00001;
        end
    end

    assign route_cur  = (state == BODY) ? route_q : route_dec;
    assign thanks_vec = {thanks_n_in, thanks_e_in, thanks_s_in, thanks_w_in, thanks_p_in};
    assign pop        = valid_out & |(route_cur & thanks_vec);
    assign push       = valid_in & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            yummy_out    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            yummy_out <= pop;
            if (valid_in && full && !pop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HDR;
            rem     <= '0;
            route_q <= '0;
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            route_q <= route_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        route_next = route_q;
        tail_int   = 1'b0;
        case (state)
            HDR: begin
                tail_int = (hdr_len == '0);
                if (pop && hdr_len != '0) begin
                    state_next = BODY;
                    rem_next   = hdr_len;
                    route_next = route_dec;
                end
            end
            BODY: begin
                tail_int = (rem == PAYLOAD_LEN'(1));
                if (pop) begin
                    rem_next = rem - PAYLOAD_LEN'(1);
                    if (rem == PAYLOAD_LEN'(1)) state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    assign data_out        = valid_out ? head : '0;
    assign tail_out        = valid_out & tail_int;
    assign route_req_n_out = valid_out & route_cur[4];
    assign route_req_e_out = valid_out & route_cur[3];
    assign route_req_s_out = valid_out & route_cur[2];
    assign route_req_w_out = valid_out & route_cur[1];
    assign route_req_p_out = valid_out & route_cur[0];

endmodule

// File: tb/tb_dynamic_input_route_buffer.sv
// Scoreboard bench: expected flits are queued at push time and compared by a
// monitor whenever the DUT hands a flit to the output port that requested it.
module tb_dynamic_input_route_buffer;

    localparam int unsigned DW  = 64;
    localparam int unsigned CID = 14;
    localparam int unsigned XY  = 8;
    localparam int unsigned PL  = 8;

    localparam logic [4:0] D_N = 5'b10000;
    localparam logic [4:0] D_E = 5'b01000;
    localparam logic [4:0] D_S = 5'b00100;
    localparam logic [4:0] D_W = 5'b00010;
    localparam logic [4:0] D_P = 5'b00001;

    logic          clk = 1'b0;
    logic          reset;
    logic [CID-1:0] my_chip_id;
    logic [XY-1:0] my_loc_x, my_loc_y;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          yummy_out;
    logic [DW-1:0] data_out;
    logic          valid_out, tail_out;
    logic          route_req_n_out, route_req_e_out, route_req_s_out, route_req_w_out, route_req_p_out;
    logic          thanks_n_in, thanks_e_in, thanks_s_in, thanks_w_in, thanks_p_in;
    logic          overflow_err;

    logic          consume;
    logic [4:0]    stray;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    dir;
        logic          tail;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    dynamic_input_route_buffer #(
        .DATA_WIDTH(DW), .CHIP_ID_WIDTH(CID), .XY_WIDTH(XY), .PAYLOAD_LEN(PL),
        .DEPTH(4), .PTR_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .my_chip_id(my_chip_id), .my_loc_x(my_loc_x), .my_loc_y(my_loc_y),
        .data_in(data_in), .valid_in(valid_in), .yummy_out(yummy_out),
        .data_out(data_out), .valid_out(valid_out), .tail_out(tail_out),
        .route_req_n_out(route_req_n_out), .route_req_e_out(route_req_e_out),
        .route_req_s_out(route_req_s_out), .route_req_w_out(route_req_w_out),
        .route_req_p_out(route_req_p_out),
        .thanks_n_in(thanks_n_in), .thanks_e_in(thanks_e_in), .thanks_s_in(thanks_s_in),
        .thanks_w_in(thanks_w_in), .thanks_p_in(thanks_p_in),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Output ports consume whatever the DUT requests of them; stray injects unrequested thanks.
    assign thanks_n_in = (consume & route_req_n_out) | stray[4];
    assign thanks_e_in = (consume & route_req_e_out) | stray[3];
    assign thanks_s_in = (consume & route_req_s_out) | stray[2];
    assign thanks_w_in = (consume & route_req_w_out) | stray[1];
    assign thanks_p_in = (consume & route_req_p_out) | stray[0];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input logic [CID-1:0] c, input logic [XY-1:0] x,
                                          input logic [XY-1:0] y, input logic [PL-1:0] len,
                                          input logic [15:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: CID]          = c;
        d[DW-CID-1 -: XY]       = x;
        d[DW-CID-XY-1 -: XY]    = y;
        d[DW-CID-2*XY-4 -: PL]  = len;
        d[15:0]                 = tag;
        return d;
    endfunction

    // Monitor
    logic pop_prev = 1'b0;
    always @(negedge clk) begin
        logic [4:0] req, thk;
        logic       pop_now;
        exp_t       e;
        if (reset) begin
            pop_prev = 1'b0;
        end else begin
            check("yummy", {63'd0, yummy_out}, {63'd0, pop_prev});
            req = {route_req_n_out, route_req_e_out, route_req_s_out, route_req_w_out, route_req_p_out};
            thk = {thanks_n_in, thanks_e_in, thanks_s_in, thanks_w_in, thanks_p_in};
            pop_now = valid_out & |(req & thk);
            if (pop_now) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pop", {63'd0, pop_now}, '0);
                end else begin
                    e = sbq.pop_front();
                    check("data", data_out, e.data);
                    check("route", {59'd0, req}, {59'd0, e.dir});
                    check("tail", {63'd0, tail_out}, {63'd0, e.tail});
                end
            end
            pop_prev = pop_now;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [4:0] dir, input logic tail, input bit keep);
        valid_in = 1'b1;
        data_in  = d;
        if (keep) sbq.push_back('{data: d, dir: dir, tail: tail});
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int target);
        consume = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (sbq.size() <= target) break;
            tick();
        end
        consume = 1'b0;
        check("drain_timeout", 64'(sbq.size()), 64'(target));
        tick();
    endtask

    task automatic do_reset();
        consume  = 1'b0;
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        sbq.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {63'd0, valid_out}, '0);
        check({tag, "_tail"}, {63'd0, tail_out}, '0);
        check({tag, "_req"}, {59'd0, route_req_n_out, route_req_e_out, route_req_s_out,
                              route_req_w_out, route_req_p_out}, '0);
        check({tag, "_data"}, data_out, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; consume = 1'b0; stray = '0;
        my_chip_id = 14'd5; my_loc_x = 8'd1; my_loc_y = 8'd1;
        tick(); tick();
        reset = 1'b0;
        check_idle("reset");
        check("reset_yummy", {63'd0, yummy_out}, '0);
        check("reset_ovf", {63'd0, overflow_err}, '0);

        // Single-flit packet heading east
        push(hdr(14'd5, 8'd3, 8'd1, 8'd0, 16'h0001), D_E, 1'b1, 1'b1);
        drain(0);
        check_idle("t1_empty");

        // Three-flit packet heading north; body flits resemble headers for other directions
        push(hdr(14'd5, 8'd1, 8'd0, 8'd2, 16'h0002), D_N, 1'b0, 1'b1);
        push(hdr(14'd5, 8'd3, 8'd1, 8'd0, 16'h00B1), D_N, 1'b0, 1'b1);
        push(hdr(14'd5, 8'd0, 8'd1, 8'd0, 16'h00B2), D_N, 1'b1, 1'b1);
        drain(0);

        // Fill, then overflow
        push(hdr(14'd5, 8'd0, 8'd1, 8'd0, 16'h0031), D_W, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd1, 8'd3, 8'd0, 16'h0032), D_S, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd1, 8'd1, 8'd0, 16'h0033), D_P, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd2, 8'd1, 8'd0, 16'h0034), D_E, 1'b1, 1'b1);
        check("t3_valid", {63'd0, valid_out}, 64'd1);
        check("t3_no_ovf", {63'd0, overflow_err}, '0);
        push(hdr(14'd5, 8'd0, 8'd0, 8'd0, 16'h0035), D_W, 1'b1, 1'b0);
        check("t3_ovf", {63'd0, overflow_err}, 64'd1);
        drain(0);
        check("t3_drained", {63'd0, valid_out}, '0);
        check("t3_ovf_sticky", {63'd0, overflow_err}, 64'd1);
        do_reset();
        check("t3_ovf_cleared", {63'd0, overflow_err}, '0);

        // Full FIFO with simultaneous push and pop
        push(hdr(14'd5, 8'd2, 8'd1, 8'd0, 16'h0041), D_E, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd0, 8'd1, 8'd0, 16'h0042), D_W, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd1, 8'd0, 8'd0, 16'h0043), D_N, 1'b1, 1'b1);
        push(hdr(14'd5, 8'd1, 8'd2, 8'd0, 16'h0044), D_S, 1'b1, 1'b1);
        consume = 1'b1;
        push(hdr(14'd5, 8'd1, 8'd1, 8'd0, 16'h0045), D_P, 1'b1, 1'b1);
        consume = 1'b0;
        check("t4_no_ovf", {63'd0, overflow_err}, '0);
        push(hdr(14'd5, 8'd3, 8'd3, 8'd0, 16'h0046), D_E, 1'b1, 1'b0);
        check("t4_still_full", {63'd0, overflow_err}, 64'd1);
        drain(0);
        check("t4_drained", {63'd0, valid_out}, '0);
        do_reset();

        // Thanks on an unselected direction must not pop
        push(hdr(14'd5, 8'd3, 8'd1, 8'd0, 16'h0051), D_E, 1'b1, 1'b1);
        stray = D_W;
        tick(); tick(); tick();
        stray = '0;
        check("stray_held", {63'd0, valid_out}, 64'd1);
        drain(0);

        // Off-chip destinations
        my_loc_x = 8'd0; my_loc_y = 8'd2;
        push(hdr(14'd9, 8'd4, 8'd4, 8'd0, 16'h0061), D_N, 1'b1, 1'b1);
        drain(0);
        my_loc_x = 8'd0; my_loc_y = 8'd0;
        push(hdr(14'd9, 8'd4, 8'd4, 8'd0, 16'h0062), D_P, 1'b1, 1'b1);
        drain(0);
        my_loc_x = 8'd1; my_loc_y = 8'd1;
        push(hdr(14'd9, 8'd4, 8'd4, 8'd0, 16'h0063), D_W, 1'b1, 1'b1);
        drain(0);

        // Reset in the middle of a packet
        push(hdr(14'd5, 8'd1, 8'd3, 8'd3, 16'h0071), D_S, 1'b0, 1'b1);
        push(64'hDEAD_0000_0000_0B01, D_S, 1'b0, 1'b1);
        push(64'hDEAD_0000_0000_0B02, D_S, 1'b0, 1'b1);
        push(64'hDEAD_0000_0000_0B03, D_S, 1'b1, 1'b1);
        drain(2);
        do_reset();
        check_idle("t6_flushed");
        tick();
        push(hdr(14'd5, 8'd0, 8'd1, 8'd0, 16'h0072), D_W, 1'b1, 1'b1);
        drain(0);
        check_idle("t6_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
